// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: default datapath widths and the load/store opcodes
// that the MEM stage decodes before handing stores to the write buffer.
package cpu_pkg;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 32;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
endpackage

// File: rtl/store_buffer_if.sv
// Bundles the three store-buffer channels: store intake, load lookup and the DM write port.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // A transfer happens on a rising edge where valid (st_valid / mem_wr_req) and
    // ready (st_ready / mem_wr_ack) are both high; the valid side holds addr/data
    // stable until then, and ready may depend combinationally on the offered addr.
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack;

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_wr_ack,
        input  st_ready, ld_hit, ld_data, mem_wr_req, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_wr_ack,
        output st_ready, ld_hit, ld_data, mem_wr_req, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/store_buf_fwd.sv
// Load forwarding: finds the youngest valid buffered entry whose address matches
// the load address and returns its data (zero when nothing matches).
module store_buf_fwd
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                     valid_i [DEPTH],
    input  logic [ADDR_W-1:0]        addr_i  [DEPTH],
    input  logic [DATA_W-1:0]        data_i  [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] tail_i,
    input  logic [ADDR_W-1:0]        ld_addr_i,
    output logic                     ld_hit_o,
    output logic [DATA_W-1:0]        ld_data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Scan backwards from the newest slot so the first match is the youngest one.
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_data_o = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail_i - PW'(i + 1);
            if (!ld_hit_o && valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
                ld_hit_o  = 1'b1;
                ld_data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Write buffer between MEM stage and data memory: circular entry queue drained
// in order through req/ack, with optional tail coalescing and load forwarding.
module store_buffer
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DEPTH    = 4,
    parameter int COALESCE = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    store_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, tail_last;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic              coal_hit, accept, alloc, retire;

    always_comb begin
        tail_last = tail_q - PW'(1);
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        // With two or more entries the tail is never the in-flight head, so it is safe to rewrite.
        coal_hit  = (COALESCE != 0) && (count_q >= CW'(2)) && (addr_q[tail_last] == bus.st_addr);
        bus.st_ready = !full || coal_hit;
        accept    = bus.st_valid && bus.st_ready;
        alloc     = accept && !coal_hit;
        bus.mem_wr_req  = !empty;
        bus.mem_wr_addr = empty ? '0 : addr_q[head_q];
        bus.mem_wr_data = empty ? '0 : data_q[head_q];
        retire    = !empty && bus.mem_wr_ack;

        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (accept && coal_hit) begin
            data_d[tail_last] = bus.st_data;
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = bus.st_addr;
            data_d[tail_q]  = bus.st_data;
            tail_d          = tail_q + PW'(1);
        end
        // alloc and retire together imply 0 < count < DEPTH, so head and tail slots differ.
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        count_d = count_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, retire};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign count = count_q;

    store_buf_fwd #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_fwd (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
        .data_i   (data_q),
        .tail_i   (tail_q),
        .ld_addr_i(bus.ld_addr),
        .ld_hit_o (bus.ld_hit),
        .ld_data_o(bus.ld_data)
    );
endmodule
